fp_muldiv_unit: RTL and testbench
=================================

# fp_muldiv_unit

Second-generation multiply/divide functional unit for the Tomasulo core, sitting between the FP mult/div reservation stations and the CDB arbiter. It has a width-parametrised multiply pipeline with full back-pressure, a separate iterative radix-2 divider that works concurrently with the multiply pipe, and a single CDB output register with request/grant handshake. It adds a flush input for mispredict/exception recovery. Arithmetic is unsigned integer (demo semantics), matching the rest of the core.

## Interface
- DATA_WIDTH, 32: operand/result width.
- TAG_WIDTH, 4: RS tag width.
- MUL_LATENCY, 4: multiply pipe stages, ≥1.
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of all in-flight work.
- dispatch_valid  input  1  RS presents an op.
- dispatch_op  input  3  `FP_DIV` (tomasulo_pkg.v) selects divide; any other code multiplies.
- dispatch_vj, dispatch_vk  input  DATA_WIDTH  operands (dividend/divisor).
- dispatch_tag  input  TAG_WIDTH  RS tag.
- dispatch_ack  output  1  combinational; op accepted this cycle.
- cdb_request  output  1  result held for CDB.
- cdb_tag  output  TAG_WIDTH  result tag.
- cdb_data  output  DATA_WIDTH  result.
- cdb_grant  input  1  arbiter accepts result this cycle.
- mul_busy, div_busy, busy  output  1  pipe occupied / divider occupied / anything in flight, including cdb_request.

## Operation
- Reset: all stage valids, divider state, done slot, and cdb_request go to 0. cdb_tag and cdb_data go to 0. Status outputs go to 0.
- Output register (OR) loads when `or_free = !cdb_request || cdb_grant`. On grant without reload, cdb_request drops. cdb_tag and cdb_data hold their value while the request is pending.
- OR source priority: the divider done slot first, then multiply stage MUL_LATENCY-1. The loser stalls.
- Multiply pipe is elastic. Stage i advances when stage i+1 is empty or advancing. The last stage advances when it is chosen to load the OR. The product is the low DATA_WIDTH bits of vj*vk, computed at entry and carried through the stages.
- Mul dispatch_ack = valid && op≠`FP_DIV` && (stage0 empty || stage0 advancing) && !flush.
- Divider FSM has three states:
  - IDLE: on ack, load dividend, divisor, tag and count=DATA_WIDTH, then go to RUN.
  - RUN: one restoring shift-subtract step per cycle. After the step where count reaches 0, go to DONE.
  - DONE: hold quotient and tag until the OR loads it, then go to IDLE.
- Div dispatch_ack = valid && op==`FP_DIV` && state==IDLE && !flush.
- Divisor 0 produces quotient all-ones. It still takes full latency.
- Divider runs in parallel with multiplies. At most one divide is in flight.
- flush (takes priority over everything at that edge):
  - clears all pipe valids.
  - returns the divider to IDLE.
  - drops cdb_request, even if cdb_grant is high the same cycle; the arbiter must ignore a grant coincident with flush.
  - forces dispatch_ack to 0.
- mul_busy = any pipe stage valid. div_busy = state≠IDLE. busy = mul_busy || div_busy || cdb_request.

## Timing
- Cycle 0 = dispatch_valid && dispatch_ack sampled at an edge.
- Multiply, unstalled: last stage valid in cycle MUL_LATENCY. cdb_request first high in cycle MUL_LATENCY+1 (5 at default).
- Divide, unstalled: DONE in cycle DATA_WIDTH+1. cdb_request in cycle DATA_WIDTH+2 (34 at default).
- Throughput:
  - Back-to-back multiplies at one per cycle, with cdb_grant held high.
  - One result per cycle out of the OR: a grant and a reload in the same cycle give a continuous request.
  - Divides are one per DATA_WIDTH+2 cycles.
- Full pipe with grant low: every stage holds and mul ack=0. After a grant, ack returns combinationally in the same cycle, because the whole pipe advances.
- Mul tail and div DONE both waiting: div loads first, and the mul tail loads on the next free OR cycle.
- Reset asserted mid-operation: all outputs go to their reset values immediately. No result from before reset is ever requested.

## Test plan
- **Single multiply:** vj=7, vk=6, tag=3, grant tied high. Required: cdb_request only in cycle 5, with tag 3 and data 42. busy=0 from cycle 6.
- **Multiply back-pressure:** 6 multiplies (vj=i+1, vk=2, tags 1..6) with grant low. Required: acks for tags 1..5, then ack=0. Release grant: results 2,4,6,8,10 come out in tag order, one per cycle; tag 6 is accepted on release, and no result is duplicated or lost.
- **Divide and zero divisor:** 100/7, tag 2. Required: data 14 in cycle 34. Then 5/0, tag 4: data 0xFFFFFFFF. A second divide offered while div_busy gets ack=0.
- **Collision:** divide 9/3 (tag 1) in cycle 0; multiply 2*3 (tag 5) issued so its tail coincides with DONE in cycle 33. Required: tag 1 data 3 first, then tag 5 data 6 in the next cycle.
- **Flush:** 3 multiplies in flight, a divide in RUN, and cdb_request pending. Assert flush with cdb_grant high in the same cycle. Required: next cycle busy=0 and cdb_request=0; no stale tag ever appears; a fresh multiply after the flush completes in 5 cycles.
- **Async reset mid-divide (cycle 10):** required immediately: cdb_request=0, cdb_tag=0, cdb_data=0, div_busy=0.

Source files
------------

// File: rtl/fp_muldiv_unit.sv
// fp_muldiv_unit: elastic multiply pipe plus iterative radix-2 divider
// sharing one CDB output register with request/grant and flush recovery.
package fp_muldiv_pkg;
   localparam logic [2:0] FP_DIV = 3'd3;
endpackage

module fp_muldiv_unit
   import fp_muldiv_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int TAG_WIDTH   = 4,
   parameter int MUL_LATENCY = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  dispatch_valid,
   input  logic [2:0]            dispatch_op,
   input  logic [DATA_WIDTH-1:0] dispatch_vj,
   input  logic [DATA_WIDTH-1:0] dispatch_vk,
   input  logic [TAG_WIDTH-1:0]  dispatch_tag,
   output logic                  dispatch_ack,
   output logic                  cdb_request,
   output logic [TAG_WIDTH-1:0]  cdb_tag,
   output logic [DATA_WIDTH-1:0] cdb_data,
   input  logic                  cdb_grant,
   output logic                  mul_busy,
   output logic                  div_busy,
   output logic                  busy
);

   localparam int W  = DATA_WIDTH;
   localparam int L  = MUL_LATENCY;
   localparam int CW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {
      D_IDLE,
      D_RUN,
      D_DONE
   } div_st_e;

   logic [L-1:0]         mv_q, mv_d;
   logic [TAG_WIDTH-1:0] mt_q [L];
   logic [TAG_WIDTH-1:0] mt_d [L];
   logic [W-1:0]         mp_q [L];
   logic [W-1:0]         mp_d [L];
   logic [L-1:0]         rdy;

   div_st_e              ds_q;
   logic [W-1:0]         rem_q, quo_q, dvs_q;
   logic [TAG_WIDTH-1:0] dtag_q;
   logic [CW-1:0]        cnt_q;
   logic [W:0]           shifted;
   logic [W:0]           diff;
   logic                 ge;

   logic                 req_q, req_d;
   logic [TAG_WIDTH-1:0] tag_q, tag_d;
   logic [W-1:0]         data_q, data_d;

   logic                 is_div, or_free;
   logic                 div_sel, mul_sel;
   logic                 mul_ack, div_ack;
   logic [W-1:0]         product;

   always_comb begin
      is_div  = (dispatch_op == FP_DIV);
      or_free = !req_q || cdb_grant;
      div_sel = (ds_q == D_DONE) && or_free && !flush;
      mul_sel = mv_q[L-1] && or_free && (ds_q != D_DONE) && !flush;
      // Ready ripples from the tail so a full pipe moves as one on grant.
      rdy[L-1] = !mv_q[L-1] || mul_sel;
      for (int i = L - 2; i >= 0; i--) begin
         rdy[i] = !mv_q[i] || rdy[i+1];
      end
      mul_ack = dispatch_valid && !is_div && rdy[0] && !flush;
      div_ack = dispatch_valid && is_div && (ds_q == D_IDLE) && !flush;
      product = dispatch_vj * dispatch_vk;
   end

   assign dispatch_ack = mul_ack || div_ack;

   always_comb begin
      mv_d = mv_q;
      mt_d = mt_q;
      mp_d = mp_q;
      if (rdy[0]) begin
         mv_d[0] = mul_ack;
         mt_d[0] = dispatch_tag;
         mp_d[0] = product;
      end
      for (int i = 1; i < L; i++) begin
         if (rdy[i]) begin
            mv_d[i] = mv_q[i-1];
            mt_d[i] = mt_q[i-1];
            mp_d[i] = mp_q[i-1];
         end
      end
      if (flush) begin
         mv_d = '0;
      end
   end

   always_comb begin
      req_d  = req_q;
      tag_d  = tag_q;
      data_d = data_q;
      unique case (1'b1)
         div_sel: begin
            req_d  = 1'b1;
            tag_d  = dtag_q;
            data_d = quo_q;
         end
         mul_sel: begin
            req_d  = 1'b1;
            tag_d  = mt_q[L-1];
            data_d = mp_q[L-1];
         end
         default: begin
            if (cdb_grant) begin
               req_d = 1'b0;
            end
         end
      endcase
      if (flush) begin
         req_d = 1'b0;
      end
   end

   always_comb begin
      shifted = {rem_q, quo_q[W-1]};
      diff    = shifted - {1'b0, dvs_q};
      ge      = (shifted >= {1'b0, dvs_q});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mv_q   <= '0;
         req_q  <= 1'b0;
         tag_q  <= '0;
         data_q <= '0;
         for (int i = 0; i < L; i++) begin
            mt_q[i] <= '0;
            mp_q[i] <= '0;
         end
      end else begin
         mv_q   <= mv_d;
         mt_q   <= mt_d;
         mp_q   <= mp_d;
         req_q  <= req_d;
         tag_q  <= tag_d;
         data_q <= data_d;
      end
   end

   // Restoring division: a zero divisor naturally yields all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ds_q   <= D_IDLE;
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         dtag_q <= '0;
         cnt_q  <= '0;
      end else if (flush) begin
         ds_q <= D_IDLE;
      end else begin
         unique case (ds_q)
            D_IDLE: begin
               if (div_ack) begin
                  rem_q  <= '0;
                  quo_q  <= dispatch_vj;
                  dvs_q  <= dispatch_vk;
                  dtag_q <= dispatch_tag;
                  cnt_q  <= CW'(W);
                  ds_q   <= D_RUN;
               end
            end
            D_RUN: begin
               rem_q <= ge ? diff[W-1:0] : shifted[W-1:0];
               quo_q <= {quo_q[W-2:0], ge};
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  ds_q <= D_DONE;
               end
            end
            D_DONE: begin
               if (div_sel) begin
                  ds_q <= D_IDLE;
               end
            end
            default: ds_q <= D_IDLE;
         endcase
      end
   end

   assign cdb_request = req_q;
   assign cdb_tag     = tag_q;
   assign cdb_data    = data_q;
   assign mul_busy    = |mv_q;
   assign div_busy    = (ds_q != D_IDLE);
   assign busy        = mul_busy || div_busy || req_q;

endmodule

// File: tb/tb_fp_muldiv_unit.sv
// Directed-vector bench for fp_muldiv_unit: multiply, back-pressure,
// divide, collision, flush and async reset.
module tb_fp_muldiv_unit;
   import fp_muldiv_pkg::*;

   localparam int W  = 32;
   localparam int TW = 4;
   localparam logic [2:0] OP_MUL = 3'd0;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          dv = 1'b0;
   logic [2:0]    op = '0;
   logic [W-1:0]  vj = '0;
   logic [W-1:0]  vk = '0;
   logic [TW-1:0] tg = '0;
   logic          ack;
   logic          req;
   logic [TW-1:0] tag;
   logic [W-1:0]  data;
   logic          grant = 1'b0;
   logic          mul_busy, div_busy, busy;
   logic          stale;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fp_muldiv_unit #(
      .DATA_WIDTH(W),
      .TAG_WIDTH(TW),
      .MUL_LATENCY(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .flush(flush),
      .dispatch_valid(dv),
      .dispatch_op(op),
      .dispatch_vj(vj),
      .dispatch_vk(vk),
      .dispatch_tag(tg),
      .dispatch_ack(ack),
      .cdb_request(req),
      .cdb_tag(tag),
      .cdb_data(data),
      .cdb_grant(grant),
      .mul_busy(mul_busy),
      .div_busy(div_busy),
      .busy(busy)
   );

   task automatic check(input string name, input logic [63:0] got,
                        input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [TW-1:0] t);
      dv = 1'b1;
      op = o;
      vj = a;
      vk = b;
      tg = t;
   endtask

   task automatic div_case(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [TW-1:0] t, input logic [W-1:0] q,
                           input bit probe);
      grant = 1'b1;
      issue(FP_DIV, a, b, t);
      @(negedge clk);
      check("div_ack", ack, 1);
      step();
      if (probe) issue(FP_DIV, 50, 5, 9);
      else dv = 1'b0;
      for (int c = 1; c <= 35; c++) begin
         @(negedge clk);
         if (probe && c == 1) begin
            check("div2_ack", ack, 0);
            check("div_busy", div_busy, 1);
         end
         check("div_req", req, c == 34);
         if (c == 34) begin
            check("div_tag", tag, t);
            check("div_data", data, q);
         end
         step();
         dv = 1'b0;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // reset state
      @(negedge clk);
      check("rst_req", req, 0);
      check("rst_tag", tag, 0);
      check("rst_data", data, 0);
      check("rst_busy", busy, 0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // single multiply
      grant = 1'b1;
      issue(OP_MUL, 7, 6, 3);
      @(negedge clk);
      check("mul_ack", ack, 1);
      step();
      dv = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         check("mul_req", req, c == 5);
         if (c == 5) begin
            check("mul_tag", tag, 3);
            check("mul_data", data, 42);
         end
         if (c >= 6) check("mul_idle", busy, 0);
         step();
      end

      // back-pressure
      grant = 1'b0;
      for (int i = 0; i < 6; i++) begin
         issue(OP_MUL, W'(i + 1), 2, TW'(i + 1));
         @(negedge clk);
         check("bp_ack", ack, i < 5);
         step();
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_hold_ack", ack, 0);
         check("bp_hold_req", req, 1);
         check("bp_hold_tag", tag, 1);
         step();
      end
      grant = 1'b1;
      @(negedge clk);
      check("bp_rel_ack", ack, 1);
      check("bp_req", req, 1);
      check("bp_tag", tag, 1);
      check("bp_data", data, 2);
      step();
      dv = 1'b0;
      for (int k = 2; k <= 6; k++) begin
         @(negedge clk);
         check("bp_req", req, 1);
         check("bp_tag", tag, TW'(k));
         check("bp_data", data, 64'(2 * k));
         step();
      end
      @(negedge clk);
      check("bp_drain_req", req, 0);
      check("bp_drain_busy", busy, 0);
      step();

      // divide, then zero divisor
      div_case(100, 7, 2, 14, 1'b1);
      div_case(5, 0, 4, 32'hFFFF_FFFF, 1'b0);

      // collision: divide DONE and multiply tail in the same cycle
      grant = 1'b1;
      issue(FP_DIV, 9, 3, 1);
      @(negedge clk);
      check("col_dack", ack, 1);
      step();
      dv = 1'b0;
      for (int c = 1; c <= 36; c++) begin
         if (c == 29) issue(OP_MUL, 2, 3, 5);
         @(negedge clk);
         if (c == 29) check("col_mack", ack, 1);
         check("col_req", req, c == 34 || c == 35);
         if (c == 34) begin
            check("col_tag1", tag, 1);
            check("col_data1", data, 3);
         end
         if (c == 35) begin
            check("col_tag2", tag, 5);
            check("col_data2", data, 6);
         end
         step();
         dv = 1'b0;
      end

      // flush with grant in the same cycle
      grant = 1'b0;
      issue(FP_DIV, 200, 3, 7);
      @(negedge clk);
      check("fl_dack", ack, 1);
      step();
      for (int c = 1; c <= 4; c++) begin
         issue(OP_MUL, 1, 1, TW'(7 + c));
         @(negedge clk);
         check("fl_mack", ack, 1);
         step();
      end
      dv = 1'b0;
      step();
      @(negedge clk);
      check("fl_pre_req", req, 1);
      check("fl_pre_tag", tag, 8);
      check("fl_pre_mbusy", mul_busy, 1);
      check("fl_pre_dbusy", div_busy, 1);
      step();
      flush = 1'b1;
      grant = 1'b1;
      issue(OP_MUL, 9, 9, 15);
      @(negedge clk);
      check("fl_ack", ack, 0);
      step();
      flush = 1'b0;
      dv = 1'b0;
      @(negedge clk);
      check("fl_busy", busy, 0);
      check("fl_req", req, 0);
      stale = 1'b0;
      for (int c = 0; c < 40; c++) begin
         step();
         @(negedge clk);
         stale = stale | req;
      end
      check("fl_stale", stale, 0);
      step();
      issue(OP_MUL, 3, 4, 12);
      @(negedge clk);
      check("fl_new_ack", ack, 1);
      step();
      dv = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         check("fl_new_req", req, c == 5);
         if (c == 5) begin
            check("fl_new_tag", tag, 12);
            check("fl_new_data", data, 12);
         end
         step();
      end

      // async reset in the middle of a divide
      issue(FP_DIV, 1000, 10, 6);
      @(negedge clk);
      check("ar_ack", ack, 1);
      step();
      dv = 1'b0;
      for (int c = 1; c < 10; c++) step();
      @(negedge clk);
      check("ar_pre_dbusy", div_busy, 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("ar_req", req, 0);
      check("ar_tag", tag, 0);
      check("ar_data", data, 0);
      check("ar_dbusy", div_busy, 0);
      check("ar_busy", busy, 0);
      step();
      step();
      rst_n = 1'b1;
      stale = 1'b0;
      for (int c = 0; c < 40; c++) begin
         step();
         @(negedge clk);
         stale = stale | req;
      end
      check("ar_stale", stale, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
